// File: rtl/led_pwm_bank.sv
// LED/GPIO output bank with per-channel OFF/ON/PWM/BLINK modes and frame-aligned, double-buffered config.
// Build option: `define LED_ACTIVE_LOW_EN to drive inverted (active-low) outputs that reset to all ones.

module led_pwm_chan #(
  parameter int PWM_W   = 4,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [PWM_W-1:0] pwm_cnt_i,
  input  logic             wrap_i,
  input  logic             load_i,
  input  logic [1:0]       mode_i,
  input  logic [PWM_W-1:0] duty_i,
  output logic             led_o
);
  typedef enum logic [1:0] {M_OFF = 2'b00, M_ON = 2'b01, M_PWM = 2'b10, M_BLINK = 2'b11} mode_e;

  mode_e            mode_q, mode_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PWM_W-1:0] blink_q, blink_d;
  logic             phase_q, phase_d;
  logic             led_q, led_d;
  logic             lvl;

  always_comb begin
    mode_d  = mode_q;
    duty_d  = duty_q;
    blink_d = blink_q;
    phase_d = phase_q;
    // A fresh config restarts the blink cadence; otherwise the counter free-runs in every mode.
    if (wrap_i) begin
      if (load_i) begin
        mode_d  = mode_e'(mode_i);
        duty_d  = duty_i;
        blink_d = '0;
        phase_d = 1'b0;
      end else if (blink_q == duty_q) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
  end

  always_comb begin
    lvl = 1'b0;
    unique case (mode_q)
      M_OFF:   lvl = 1'b0;
      M_ON:    lvl = 1'b1;
      M_PWM:   lvl = (pwm_cnt_i < duty_q);
      M_BLINK: lvl = phase_q;
      default: lvl = 1'b0;
    endcase
    led_d = lvl ^ ACT_LOW;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mode_q  <= M_OFF;
      duty_q  <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      led_q   <= ACT_LOW;
    end else begin
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;
endmodule

module led_pwm_bank #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_W    = 4,
  parameter int PRESCALE = 100,
  parameter int CH_W     = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_W-1:0]    cfg_duty,
  output logic                frame_sync,
  output logic [NUM_LEDS-1:0] leds_leds
);
`ifdef LED_ACTIVE_LOW_EN
  localparam bit ACT_LOW = 1'b1;
`else
  localparam bit ACT_LOW = 1'b0;
`endif
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic             fs_q;
  logic             pend_q, pend_d;
  logic [CH_W-1:0]  sh_chan_q, sh_chan_d;
  logic [1:0]       sh_mode_q, sh_mode_d;
  logic [PWM_W-1:0] sh_duty_q, sh_duty_d;
  logic             tick, wrap, accept, chan_ok;

  assign tick      = (pre_q == PRE_W'(PRESCALE - 1));
  assign wrap      = tick && (pwm_q == '1);
  assign cfg_ready = ~pend_q;
  assign accept    = cfg_valid && cfg_ready;
  assign chan_ok   = ({1'b0, cfg_chan} < (CH_W + 1)'(NUM_LEDS));

  always_comb begin
    pre_d     = tick ? '0 : pre_q + 1'b1;
    pwm_d     = tick ? pwm_q + 1'b1 : pwm_q;
    pend_d    = pend_q;
    sh_chan_d = sh_chan_q;
    sh_mode_d = sh_mode_q;
    sh_duty_d = sh_duty_q;
    if (wrap && pend_q) pend_d = 1'b0;
    // Out-of-range channels complete the handshake but are never staged.
    if (accept && chan_ok) begin
      pend_d    = 1'b1;
      sh_chan_d = cfg_chan;
      sh_mode_d = cfg_mode;
      sh_duty_d = cfg_duty;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pre_q     <= '0;
      pwm_q     <= '0;
      fs_q      <= 1'b0;
      pend_q    <= 1'b0;
      sh_chan_q <= '0;
      sh_mode_q <= '0;
      sh_duty_q <= '0;
    end else begin
      pre_q     <= pre_d;
      pwm_q     <= pwm_d;
      fs_q      <= wrap;
      pend_q    <= pend_d;
      sh_chan_q <= sh_chan_d;
      sh_mode_q <= sh_mode_d;
      sh_duty_q <= sh_duty_d;
    end
  end

  assign frame_sync = fs_q;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    logic load;
    assign load = wrap && pend_q && (sh_chan_q == CH_W'(i));
    led_pwm_chan #(.PWM_W(PWM_W), .ACT_LOW(ACT_LOW)) u_ch (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .pwm_cnt_i (pwm_q),
      .wrap_i    (wrap),
      .load_i    (load),
      .mode_i    (sh_mode_q),
      .duty_i    (sh_duty_q),
      .led_o     (leds_leds[i])
    );
  end
endmodule
